// File: rtl/param_password_lock_if.sv
// Keypad/actuator bundle for the password lock: entry strobes in, status out.
// Latency: n/a (wiring only); every status signal is driven from a flop in the lock.
// Backpressure: none; the lock handles one strobe per cycle and never stalls.
//
// Signals:
//   enter, passin              login strobe and the password sampled with it
//   chg_pass, newpass,         password-change strobe, requested value and
//   confirm_pass               its confirmation copy
//   relock                     force an open door back to locked
//   access, alarm, locked_out  state indicators (OPEN / ALARM / LOCKOUT)
//   fail_cnt                   consecutive wrong entries
//   pw_changed, pw_change_err  single-cycle results of a change request
interface param_password_lock_if #(
    parameter int PW_W  = 16,
    parameter int CNT_W = 2
);
    logic             enter;
    logic [PW_W-1:0]  passin;
    logic             chg_pass;
    logic [PW_W-1:0]  newpass;
    logic [PW_W-1:0]  confirm_pass;
    logic             relock;
    logic             access;
    logic             alarm;
    logic             locked_out;
    logic [CNT_W-1:0] fail_cnt;
    logic             pw_changed;
    logic             pw_change_err;

    // Keypad / entry-logic side.
    modport master (
        output enter, passin, chg_pass, newpass, confirm_pass, relock,
        input  access, alarm, locked_out, fail_cnt, pw_changed, pw_change_err
    );

    // Lock side.
    modport slave (
        input  enter, passin, chg_pass, newpass, confirm_pass, relock,
        output access, alarm, locked_out, fail_cnt, pw_changed, pw_change_err
    );
endinterface

// File: rtl/param_password_lock.sv
// Password lock with attempt limit, timed lockout, alarm escalation and auto-relocking window.
// Latency: one cycle; an input sampled at edge N shows up on the outputs right after edge N.
// Backpressure: none; every strobe is consumed (or deliberately ignored) the cycle it arrives.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset; returns to LOCKED with the default password
//   bus   param_password_lock_if slave modport (entry strobes in, status out)
module param_password_lock #(
    parameter int              PW_W           = 16,
    parameter logic [PW_W-1:0] DEFAULT_PW     = 16'h1234,
    parameter logic [PW_W-1:0] MASTER_PW      = 16'hABCD,
    parameter int              MAX_TRIES      = 3,
    parameter int              LOCKOUT_CYCLES = 8,
    parameter int              MAX_LOCKOUTS   = 2,
    parameter int              OPEN_CYCLES    = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    param_password_lock_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);
    localparam int LO_W  = $clog2(MAX_LOCKOUTS + 1);
    localparam int OT_W  = (OPEN_CYCLES > 1)    ? $clog2(OPEN_CYCLES)    : 1;
    localparam int LT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] TRIES_MAX  = CNT_W'(MAX_TRIES);
    localparam logic [CNT_W:0]   TRIES_WIDE = (CNT_W + 1)'(MAX_TRIES);
    localparam logic [LO_W-1:0]  LO_MAX     = LO_W'(MAX_LOCKOUTS);
    localparam logic [OT_W-1:0]  OPEN_LOAD  = OT_W'(OPEN_CYCLES - 1);
    localparam logic [LT_W-1:0]  LOCK_LOAD  = LT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOCKED  = 2'd0,
        S_OPEN    = 2'd1,
        S_LOCKOUT = 2'd2,
        S_ALARM   = 2'd3
    } state_t;

    // Current state and working registers.
    state_t           state;
    logic [PW_W-1:0]  user_pw;
    logic [CNT_W-1:0] fail_cnt_q;
    logic [LO_W-1:0]  lo_cnt;
    logic [OT_W-1:0]  open_tmr;
    logic [LT_W-1:0]  lock_tmr;

    // Registered outputs.
    logic access_q;
    logic alarm_q;
    logic locked_out_q;
    logic pw_changed_q;
    logic pw_change_err_q;

    // Next-state values.
    state_t           state_n;
    logic [PW_W-1:0]  user_pw_n;
    logic [CNT_W-1:0] fail_n;
    logic [LO_W-1:0]  lo_n;
    logic [OT_W-1:0]  open_n;
    logic [LT_W-1:0]  lock_n;
    logic             chg_ok_n;
    logic             chg_err_n;

    logic match_user;
    logic match_master;
    logic any_match;
    logic fail_last;
    logic chg_valid;
    logic [LO_W-1:0] lo_inc;

    assign match_user   = (bus.passin == user_pw);
    assign match_master = (bus.passin == MASTER_PW);
    assign any_match    = match_user | match_master;

    // This wrong entry is the one that reaches the attempt limit. Widened by
    // one bit so the compare is safe even when MAX_TRIES fills CNT_W exactly.
    assign fail_last = (({1'b0, fail_cnt_q} + (CNT_W + 1)'(1)) == TRIES_WIDE);

    // Lockout count saturates at the escalation threshold.
    assign lo_inc = (lo_cnt == LO_MAX) ? lo_cnt : lo_cnt + LO_W'(1);

    // A new password may never alias the master, otherwise the master would
    // lose its role as the only way out of LOCKOUT/ALARM.
    assign chg_valid = (bus.newpass == bus.confirm_pass) && (bus.newpass != MASTER_PW);

    always_comb begin
        state_n   = state;
        user_pw_n = user_pw;
        fail_n    = fail_cnt_q;
        lo_n      = lo_cnt;
        open_n    = open_tmr;
        lock_n    = lock_tmr;
        chg_ok_n  = 1'b0;
        chg_err_n = 1'b0;

        case (state)
            S_LOCKED: begin
                // A change request outside OPEN is refused; login still proceeds.
                if (bus.chg_pass) begin
                    chg_err_n = 1'b1;
                end
                if (bus.enter) begin
                    if (any_match) begin
                        state_n = S_OPEN;
                        fail_n  = '0;
                        open_n  = OPEN_LOAD;
                        // Only the real user proves the lockouts were benign.
                        if (match_user) begin
                            lo_n = '0;
                        end
                    end else if (fail_last) begin
                        fail_n = TRIES_MAX;
                        lo_n   = lo_inc;
                        if (lo_inc == LO_MAX) begin
                            state_n = S_ALARM;
                        end else begin
                            state_n = S_LOCKOUT;
                            lock_n  = LOCK_LOAD;
                        end
                    end else begin
                        fail_n = fail_cnt_q + CNT_W'(1);
                    end
                end
            end

            S_OPEN: begin
                if (bus.chg_pass) begin
                    // The change owns this cycle: relock and enter are dropped,
                    // and the window keeps running (held at 0 so it expires next).
                    if (chg_valid) begin
                        user_pw_n = bus.newpass;
                        chg_ok_n  = 1'b1;
                    end else begin
                        chg_err_n = 1'b1;
                    end
                    if (open_tmr != '0) begin
                        open_n = open_tmr - OT_W'(1);
                    end
                end else if (bus.relock) begin
                    state_n = S_LOCKED;
                end else if (bus.enter && any_match) begin
                    open_n = OPEN_LOAD;
                end else if (open_tmr == '0) begin
                    state_n = S_LOCKED;
                end else begin
                    open_n = open_tmr - OT_W'(1);
                end
            end

            S_LOCKOUT: begin
                if (bus.chg_pass) begin
                    chg_err_n = 1'b1;
                end
                if (bus.enter && match_master) begin
                    state_n = S_LOCKED;
                    fail_n  = '0;
                    lo_n    = '0;
                end else if (lock_tmr == '0) begin
                    // Lockout count survives so repeated lockouts escalate.
                    state_n = S_LOCKED;
                    fail_n  = '0;
                end else begin
                    lock_n = lock_tmr - LT_W'(1);
                end
            end

            S_ALARM: begin
                if (bus.chg_pass) begin
                    chg_err_n = 1'b1;
                end
                if (bus.enter && match_master) begin
                    state_n = S_LOCKED;
                    fail_n  = '0;
                    lo_n    = '0;
                end
            end

            default: begin
                state_n = S_LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_LOCKED;
            user_pw         <= DEFAULT_PW;
            fail_cnt_q      <= '0;
            lo_cnt          <= '0;
            open_tmr        <= '0;
            lock_tmr        <= '0;
            access_q        <= 1'b0;
            alarm_q         <= 1'b0;
            locked_out_q    <= 1'b0;
            pw_changed_q    <= 1'b0;
            pw_change_err_q <= 1'b0;
        end else begin
            state           <= state_n;
            user_pw         <= user_pw_n;
            fail_cnt_q      <= fail_n;
            lo_cnt          <= lo_n;
            open_tmr        <= open_n;
            lock_tmr        <= lock_n;
            // Indicators decode the next state so they line up with it.
            access_q        <= (state_n == S_OPEN);
            alarm_q         <= (state_n == S_ALARM);
            locked_out_q    <= (state_n == S_LOCKOUT);
            pw_changed_q    <= chg_ok_n;
            pw_change_err_q <= chg_err_n;
        end
    end

    assign bus.access        = access_q;
    assign bus.alarm         = alarm_q;
    assign bus.locked_out    = locked_out_q;
    assign bus.fail_cnt      = fail_cnt_q;
    assign bus.pw_changed    = pw_changed_q;
    assign bus.pw_change_err = pw_change_err_q;

endmodule

// File: tb/tb_param_password_lock.sv
// Directed bench for param_password_lock with a scoreboard of expected output vectors.
// Latency: each step pushes the expectation, clocks once, then pops and compares #1 after the edge.
// Backpressure: none; the bench drives one step per clock.
module tb_param_password_lock;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    param_password_lock_if #(.PW_W(16), .CNT_W(2)) pif ();

    param_password_lock #(
        .PW_W           (16),
        .DEFAULT_PW     (16'h1234),
        .MASTER_PW      (16'hABCD),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (8),
        .MAX_LOCKOUTS   (2),
        .OPEN_CYCLES    (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (pif)
    );

    int checks = 0;
    int errors = 0;

    // Expected output vector: {access, alarm, locked_out, fail_cnt[1:0], pw_changed, pw_change_err}
    logic [6:0] exp_q[$];
    string      tag_q[$];

    function automatic logic [6:0] ev(input logic a, input logic al, input logic lo,
                                      input logic [1:0] fc, input logic pc, input logic pe);
        return {a, al, lo, fc, pc, pe};
    endfunction

    function automatic logic [6:0] observed();
        return {pif.access, pif.alarm, pif.locked_out, pif.fail_cnt, pif.pw_changed, pif.pw_change_err};
    endfunction

    task automatic check_now(input string tag, input logic [6:0] e);
        logic [6:0] o;
        o = observed();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed {acc,alm,lo,fc,pc,pe}=%b required %b", tag, o, e);
        end
    endtask

    task automatic clear_inputs();
        pif.enter        = 1'b0;
        pif.passin       = 16'h0;
        pif.chg_pass     = 1'b0;
        pif.newpass      = 16'h0;
        pif.confirm_pass = 16'h0;
        pif.relock       = 1'b0;
    endtask

    // One clocked step: drive, record expectation, clock, compare.
    task automatic step(input logic en, input logic [15:0] pin, input logic chg,
                        input logic [15:0] np, input logic [15:0] cp, input logic rl,
                        input logic [6:0] e, input string tag);
        logic [6:0] x;
        string      t;
        pif.enter        = en;
        pif.passin       = pin;
        pif.chg_pass     = chg;
        pif.newpass      = np;
        pif.confirm_pass = cp;
        pif.relock       = rl;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        clear_inputs();
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed 0 entries required 1");
        end else begin
            x = exp_q.pop_front();
            t = tag_q.pop_front();
            check_now(t, x);
        end
    endtask

    task automatic idle(input logic [6:0] e, input string tag);
        step(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, e, tag);
    endtask

    task automatic login(input logic [15:0] pw, input logic [6:0] e, input string tag);
        step(1'b1, pw, 1'b0, 16'h0, 16'h0, 1'b0, e, tag);
    endtask

    task automatic change(input logic [15:0] np, input logic [15:0] cp, input logic [6:0] e, input string tag);
        step(1'b0, 16'h0, 1'b1, np, cp, 1'b0, e, tag);
    endtask

    task automatic do_relock(input logic [6:0] e, input string tag);
        step(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, e, tag);
    endtask

    // Three wrong entries from fail_cnt=0; last one lands in LOCKOUT or ALARM.
    task automatic three_wrong(input logic to_alarm, input string tag);
        login(16'h0000, ev(0, 0, 0, 2'd1, 0, 0), {tag, "_w1"});
        login(16'h0000, ev(0, 0, 0, 2'd2, 0, 0), {tag, "_w2"});
        login(16'h0000, ev(0, to_alarm, !to_alarm, 2'd3, 0, 0), {tag, "_w3"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] e0;
        e0 = 7'b0;
        clear_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", e0);
        rstn = 1'b1;

        // 1: default password opens for exactly 16 cycles.
        login(16'h1234, ev(1, 0, 0, 2'd0, 0, 0), "t1_open");
        for (int i = 0; i < 15; i++) idle(ev(1, 0, 0, 2'd0, 0, 0), "t1_window");
        idle(e0, "t1_expire");

        // 2: three misses -> 8-cycle lockout; user password ignored inside it.
        three_wrong(1'b0, "t2");
        for (int i = 0; i < 7; i++) begin
            if (i == 3) login(16'h1234, ev(0, 0, 1, 2'd3, 0, 0), "t2_user_ignored");
            else        idle(ev(0, 0, 1, 2'd3, 0, 0), "t2_lockout");
        end
        idle(e0, "t2_lockout_end");

        // 3: second lockout without a success escalates to ALARM.
        three_wrong(1'b1, "t3");
        for (int i = 0; i < 10; i++) begin
            if (i == 2)      login(16'h1234, ev(0, 1, 0, 2'd3, 0, 0), "t3_user_ignored");
            else if (i == 4) do_relock(ev(0, 1, 0, 2'd3, 0, 0), "t3_relock_ignored");
            else if (i == 6) change(16'h5555, 16'h5555, ev(0, 1, 0, 2'd3, 0, 1), "t3_chg_err");
            else             idle(ev(0, 1, 0, 2'd3, 0, 0), "t3_alarm_hold");
        end
        login(16'hABCD, e0, "t3_master_exit");

        // Master exit cleared the lockout count: next three misses only lock out.
        three_wrong(1'b0, "t3b");
        login(16'hABCD, e0, "t3b_master_in_lockout");
        three_wrong(1'b0, "t3c");
        for (int i = 0; i < 7; i++) idle(ev(0, 0, 1, 2'd3, 0, 0), "t3c_lockout");
        idle(e0, "t3c_lockout_end");

        // 4: password change inside OPEN (user success clears lockout count).
        login(16'h1234, ev(1, 0, 0, 2'd0, 0, 0), "t4_open");
        change(16'h5555, 16'h5555, ev(1, 0, 0, 2'd0, 1, 0), "t4_chg_ok");
        change(16'h5555, 16'h5556, ev(1, 0, 0, 2'd0, 0, 1), "t4_chg_mismatch");
        change(16'hABCD, 16'hABCD, ev(1, 0, 0, 2'd0, 0, 1), "t4_chg_master");
        login(16'h0000, ev(1, 0, 0, 2'd0, 0, 0), "t4_wrong_in_open");
        do_relock(e0, "t4_relock");
        login(16'h1234, ev(0, 0, 0, 2'd1, 0, 0), "t4_old_pw_fails");
        login(16'h5555, ev(1, 0, 0, 2'd0, 0, 0), "t4_new_pw_opens");
        idle(ev(1, 0, 0, 2'd0, 0, 0), "t4_open_c2");
        do_relock(e0, "t4_relock_c3");
        three_wrong(1'b0, "t4_lo_cleared");
        for (int i = 0; i < 7; i++) idle(ev(0, 0, 1, 2'd3, 0, 0), "t4_lockout");
        idle(e0, "t4_lockout_end");

        // 5a: change and enter together on the last window cycle: enter must not reload.
        login(16'h5555, ev(1, 0, 0, 2'd0, 0, 0), "t5_open");
        for (int i = 0; i < 15; i++) idle(ev(1, 0, 0, 2'd0, 0, 0), "t5_window");
        step(1'b1, 16'h5555, 1'b1, 16'h7777, 16'h7777, 1'b0, ev(1, 0, 0, 2'd0, 1, 0), "t5_chg_beats_enter");
        idle(e0, "t5_no_reload");
        login(16'h5555, ev(0, 0, 0, 2'd1, 0, 0), "t5_prev_pw_fails");
        login(16'h7777, ev(1, 0, 0, 2'd0, 0, 0), "t5_changed_pw_opens");

        // 5b: change request while LOCKED is refused.
        do_relock(e0, "t5_relock");
        change(16'h9999, 16'h9999, ev(0, 0, 0, 2'd0, 0, 1), "t5_chg_locked");
        login(16'h9999, ev(0, 0, 0, 2'd1, 0, 0), "t5_refused_pw_fails");
        login(16'h7777, ev(1, 0, 0, 2'd0, 0, 0), "t5_pw_unchanged");

        // 6a: asynchronous reset in the middle of the OPEN window.
        idle(ev(1, 0, 0, 2'd0, 0, 0), "t6_open");
        #2 rstn = 1'b0;
        #1 check_now("t6_rst_mid_open", e0);
        #1 rstn = 1'b1;
        login(16'h7777, ev(0, 0, 0, 2'd1, 0, 0), "t6_changed_pw_gone");
        login(16'h1234, ev(1, 0, 0, 2'd0, 0, 0), "t6_default_back");
        do_relock(e0, "t6_relock");

        // 6b: asynchronous reset mid-lockout clears fail and lockout counts.
        three_wrong(1'b0, "t6_lk");
        idle(ev(0, 0, 1, 2'd3, 0, 0), "t6_lockout");
        #2 rstn = 1'b0;
        #1 check_now("t6_rst_mid_lockout", e0);
        #1 rstn = 1'b1;
        three_wrong(1'b0, "t6_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
